// File: rtl/pll_lock_sequencer.sv
// Power-up and relock sequencer for the HDMI rPLL: holds the PLL in reset, qualifies LOCK,
// then releases the CLKDIV/serializer reset and finally the system reset; counts restarts.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 270000,
    parameter int STABLE_CYCLES = 2700,
    parameter int DIV_CYCLES    = 8,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock_i,
    input  logic       force_relock_i,
    output logic       pll_reset_o,
    output logic       clkdiv_reset_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic [7:0] relock_count_o
);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_DIV_REL,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, lock_s_q;
    logic             restart;
    logic [7:0]       relock_q, relock_d;
    logic             pll_rst_q, pll_rst_d;
    logic             div_rst_q, div_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        cnt_d     = cnt_q;
        relock_d  = relock_q;
        pll_rst_d = 1'b1;
        div_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;

        // A forced request or a lost lock outranks every normal transition.
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (force_relock_i)             restart = 1'b1;
                else if (lock_s_q)              state_d = ST_STABLE;
                else if (cnt_q == TIMEOUT_LAST) restart = 1'b1;
            end
            ST_STABLE: begin
                if (force_relock_i || !lock_s_q) restart = 1'b1;
                else if (cnt_q == STABLE_LAST)   state_d = ST_DIV_REL;
            end
            ST_DIV_REL: begin
                if (force_relock_i || !lock_s_q) restart = 1'b1;
                else if (cnt_q == DIV_LAST)      state_d = ST_RUN;
            end
            ST_RUN: begin
                if (force_relock_i || !lock_s_q) restart = 1'b1;
            end
            default: state_d = ST_PLL_RST;
        endcase

        if (restart) begin
            state_d = ST_PLL_RST;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end

        if (state_d != state_q) cnt_d = '0;
        else if (state_q != ST_RUN) cnt_d = cnt_q + 1'b1;

        // Outputs decode the next state so they switch on the same edge as the state register.
        case (state_d)
            ST_WAIT_LOCK, ST_STABLE: pll_rst_d = 1'b0;
            ST_DIV_REL: begin
                pll_rst_d = 1'b0;
                div_rst_d = 1'b0;
            end
            ST_RUN: begin
                pll_rst_d = 1'b0;
                div_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            relock_q  <= 8'd0;
            pll_rst_q <= 1'b1;
            div_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= pll_lock_i;
            lock_s_q  <= sync1_q;
            relock_q  <= relock_d;
            pll_rst_q <= pll_rst_d;
            div_rst_q <= div_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_reset_o    = pll_rst_q;
    assign clkdiv_reset_o = div_rst_q;
    assign sys_reset_o    = sys_rst_q;
    assign ready_o        = ready_q;
    assign relock_count_o = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised and directed bench for pll_lock_sequencer: a phase/timer reference model queues
// the expected outputs for every clock edge and a monitor compares them against the DUT.
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TO_C  = 50;
    localparam int STB_C = 10;
    localparam int DIV_C = 3;

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_DIVREL = 3;
    localparam int PH_RUN    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       force_relock_i = 1'b0;
    logic       pll_reset_o, clkdiv_reset_o, sys_reset_o, ready_o;
    logic [7:0] relock_count_o;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .STABLE_CYCLES(STB_C),
        .DIV_CYCLES   (DIV_C),
        .CNT_W        (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pll_lock_i    (pll_lock_i),
        .force_relock_i(force_relock_i),
        .pll_reset_o   (pll_reset_o),
        .clkdiv_reset_o(clkdiv_reset_o),
        .sys_reset_o   (sys_reset_o),
        .ready_o       (ready_o),
        .relock_count_o(relock_count_o)
    );

    always #5 clk = ~clk;

    // Expected output word: {pll_reset, clkdiv_reset, sys_reset, ready, relock_count}
    logic [11:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: current phase, cycles spent in it, restart tally, lock pipeline.
    int m_phase = PH_RESET;
    int m_time  = 0;
    int m_count = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    task automatic model_step(input bit r, input bit raw, input bit f);
        bit ls;
        bit restart;
        int nxt;
        int released;
        if (r) begin
            m_phase = PH_RESET;
            m_time  = 0;
            m_count = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            ls      = m_s2;
            m_s2    = m_s1;
            m_s1    = raw;
            restart = 1'b0;
            nxt     = m_phase;
            if (m_phase == PH_RESET) begin
                if (m_time + 1 >= RST_C) nxt = PH_WAIT;
            end else if (f || (m_phase != PH_WAIT && !ls)) begin
                restart = 1'b1;
            end else if (m_phase == PH_WAIT) begin
                if (ls) nxt = PH_SETTLE;
                else if (m_time + 1 >= TO_C) restart = 1'b1;
            end else if (m_phase == PH_SETTLE) begin
                if (m_time + 1 >= STB_C) nxt = PH_DIVREL;
            end else if (m_phase == PH_DIVREL) begin
                if (m_time + 1 >= DIV_C) nxt = PH_RUN;
            end
            if (restart) begin
                nxt = PH_RESET;
                if (m_count < 255) m_count++;
            end
            m_time  = (nxt == m_phase) ? m_time + 1 : 0;
            m_phase = nxt;
        end
        // Number of resets released so far, in release order.
        case (m_phase)
            PH_RESET:            released = 0;
            PH_WAIT, PH_SETTLE:  released = 1;
            PH_DIVREL:           released = 2;
            default:             released = 3;
        endcase
        exp_q.push_back({released < 1, released < 2, released < 3, released == 3, 8'(m_count)});
    endtask

    // Drives inputs for the next edge, records the model's expectation, then advances one cycle.
    task automatic cyc(input bit r, input bit l, input bit f);
        reset          = r;
        pll_lock_i     = l;
        force_relock_i = f;
        model_step(r, l, f);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int n);
        int low_left;
        bit l, f, r;
        low_left = 0;
        for (int i = 0; i < n; i++) begin
            if (low_left > 0) low_left--;
            else if ($urandom_range(0, 119) == 0) low_left = $urandom_range(1, 6);
            l = (low_left == 0);
            f = ($urandom_range(0, 249) == 0);
            r = ($urandom_range(0, 799) == 0);
            cyc(r, l, f);
        end
    endtask

    initial begin : monitor
        logic [11:0] e;
        logic [11:0] got;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {pll_reset_o, clkdiv_reset_o, sys_reset_o, ready_o, relock_count_o};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got pll=%b div=%b sys=%b rdy=%b cnt=%0d, expected pll=%b div=%b sys=%b rdy=%b cnt=%0d",
                             $time, got[11], got[10], got[9], got[8], got[7:0],
                             e[11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) cyc(1'b1, 1'b0, 1'b0);

        // Clean power-up: lock arrives at cycle 20 and stays.
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
        repeat (60) cyc(1'b0, 1'b1, 1'b0);

        // One-cycle lock glitch in RUN.
        cyc(1'b0, 1'b0, 1'b0);
        repeat (60) cyc(1'b0, 1'b1, 1'b0);

        // Force coinciding with synchronised lock loss, then force during the PLL reset.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (60) cyc(1'b0, 1'b1, 1'b0);

        // Lock lost while still qualifying.
        cyc(1'b0, 1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        repeat (60) cyc(1'b0, 1'b1, 1'b0);

        // Reset asserted around the CLKDIV release window.
        for (int k = 16; k <= 20; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            repeat (k) cyc(1'b0, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b1, 1'b0);

        // Lock arrival swept across the timeout boundary.
        for (int d = 44; d <= 60; d++) begin
            cyc(1'b1, 1'b0, 1'b0);
            repeat (d) cyc(1'b0, 1'b0, 1'b0);
            repeat (30) cyc(1'b0, 1'b1, 1'b0);
        end

        // Lock never comes: repeated timeouts drive the restart count into saturation.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (300 * (RST_C + TO_C) + 60) cyc(1'b0, 1'b0, 1'b0);
        repeat (60) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (40) cyc(1'b0, 1'b1, 1'b0);

        // Random lock glitches, forced relocks and resets.
        cyc(1'b1, 1'b1, 1'b0);
        rand_phase(6000);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
